pc_sequencer: RTL and testbench

Next-PC controller for the MIPS fetch path; owns the program counter register and decides its value every cycle.
- Handles sequential +4 stepping, stalls and global clock enable.
- Implements the MIPS branch delay slot and halt-on-jump-to-zero.
- Drives the fetch address and the CPU `active` flag.

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the pipeline front end and pc_sequencer.
// Optional PC_ALIGN_CHECK_EN adds the addr_fault status line.
interface pc_sequencer_if;
   logic        clk_enable;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] pc_out;
   logic        fetch_en;
   logic        delay_slot;
   logic        active;
`ifdef PC_ALIGN_CHECK_EN
   logic        addr_fault;
`endif

`ifdef PC_ALIGN_CHECK_EN
   modport master (
      output clk_enable, stall, redirect_valid, redirect_target,
      input  pc_out, fetch_en, delay_slot, active, addr_fault
   );
   modport slave (
      input  clk_enable, stall, redirect_valid, redirect_target,
      output pc_out, fetch_en, delay_slot, active, addr_fault
   );
`else
   modport master (
      output clk_enable, stall, redirect_valid, redirect_target,
      input  pc_out, fetch_en, delay_slot, active
   );
   modport slave (
      input  clk_enable, stall, redirect_valid, redirect_target,
      output pc_out, fetch_en, delay_slot, active
   );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// MIPS next-PC controller: +4 stepping, branch delay slot, halt on jump to HALT_ADDR.
// Optional PC_ALIGN_CHECK_EN halts with addr_fault on a misaligned committed target.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000,
   parameter logic [31:0] PC_STEP      = 32'd4
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);

   localparam logic [1:0] StRun  = 2'd0;
   localparam logic [1:0] StSlot = 2'd1;
   localparam logic [1:0] StHalt = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pending_q, pending_d;
   logic        slot_q, slot_d;
   logic        active_q, active_d;
   logic        adv;
   logic [31:0] pc_inc;
   logic [31:0] target_in;
`ifdef PC_ALIGN_CHECK_EN
   logic        fault_q, fault_d;
`endif

   assign adv    = bus.clk_enable & ~bus.stall & (state_q != StHalt);
   assign pc_inc = pc_q + PC_STEP;

`ifdef PC_ALIGN_CHECK_EN
   assign target_in = bus.redirect_target;
`else
   // Without the checker a misaligned target is silently word-aligned at capture.
   assign target_in = bus.redirect_target & 32'hFFFF_FFFC;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pending_d = pending_q;
      slot_d    = slot_q;
      active_d  = active_q;
`ifdef PC_ALIGN_CHECK_EN
      fault_d   = fault_q;
`endif
      if (adv) begin
         case (state_q)
            StRun: begin
               pc_d = pc_inc;
               if (bus.redirect_valid) begin
                  pending_d = target_in;
                  slot_d    = 1'b1;
                  state_d   = StSlot;
               end
            end
            StSlot: begin
               // A redirect arriving here would be a branch in a delay slot; it is ignored.
               slot_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
               if (pending_q[1:0] != 2'b00) begin
                  state_d  = StHalt;
                  active_d = 1'b0;
                  fault_d  = 1'b1;
               end else begin
                  pc_d = pending_q;
                  if (pending_q == HALT_ADDR) begin
                     state_d  = StHalt;
                     active_d = 1'b0;
                  end else begin
                     state_d = StRun;
                  end
               end
`else
               pc_d = pending_q;
               if (pending_q == HALT_ADDR) begin
                  state_d  = StHalt;
                  active_d = 1'b0;
               end else begin
                  state_d = StRun;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StRun;
         pc_q      <= RESET_VECTOR;
         pending_q <= 32'h0;
         slot_q    <= 1'b0;
         active_q  <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
         fault_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pending_q <= pending_d;
         slot_q    <= slot_d;
         active_q  <= active_d;
`ifdef PC_ALIGN_CHECK_EN
         fault_q   <= fault_d;
`endif
      end
   end

   assign bus.pc_out     = pc_q;
   assign bus.delay_slot = slot_q;
   assign bus.active     = active_q;
   assign bus.fetch_en   = (state_q != StHalt) & bus.clk_enable & ~bus.stall;
`ifdef PC_ALIGN_CHECK_EN
   assign bus.addr_fault = fault_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written reset/halt sequences,
// then random traffic against a queue-based reference model.
module tb_pc_sequencer;
   localparam logic [31:0] RV   = 32'hBFC00000;
   localparam logic [31:0] HALT = 32'h00000000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   pc_sequencer_if bus ();

   pc_sequencer #(
      .RESET_VECTOR(RV),
      .HALT_ADDR   (HALT),
      .PC_STEP     (32'd4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          ce;
      bit          st;
      bit          rv;
      logic [31:0] tgt;
      logic [31:0] pc;
      bit          slot;
      bit          act;
      bit          fe;
   } vec_t;

   vec_t vecs[$];

   // Reference model: the in-flight redirect lives in a queue of at most one target.
   logic [31:0] m_pc;
   logic [31:0] m_pend[$];
   bit          m_halted;
   bit          m_fault;

   function automatic vec_t mk(bit ce, bit st, bit rv, logic [31:0] tgt, logic [31:0] pc,
                               bit slot, bit act, bit fe);
      vec_t v;
      v.ce = ce; v.st = st; v.rv = rv; v.tgt = tgt;
      v.pc = pc; v.slot = slot; v.act = act; v.fe = fe;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit ce, bit st, bit rv, logic [31:0] tgt);
      bus.clk_enable      = ce;
      bus.stall           = st;
      bus.redirect_valid  = rv;
      bus.redirect_target = tgt;
   endtask

   task automatic model_reset();
      m_pc     = RV;
      m_pend   = {};
      m_halted = 0;
      m_fault  = 0;
   endtask

   task automatic model_edge(bit ce, bit st, bit rv, logic [31:0] tgt);
      logic [31:0] t;
      if (m_halted || !ce || st) return;
      if (m_pend.size() != 0) begin
         t = m_pend.pop_front();
`ifdef PC_ALIGN_CHECK_EN
         if (t[1:0] != 2'b00) begin
            m_halted = 1;
            m_fault  = 1;
            return;
         end
`endif
         m_pc = t;
         if (t == HALT) m_halted = 1;
      end else begin
         m_pc = m_pc + 32'd4;
`ifdef PC_ALIGN_CHECK_EN
         if (rv) m_pend.push_back(tgt);
`else
         if (rv) m_pend.push_back(tgt & 32'hFFFF_FFFC);
`endif
      end
   endtask

   task automatic model_check(string tag, bit ce, bit st);
      check({tag, ".pc"}, bus.pc_out, m_pc);
      check({tag, ".slot"}, {31'b0, bus.delay_slot}, {31'b0, m_pend.size() != 0});
      check({tag, ".active"}, {31'b0, bus.active}, {31'b0, !m_halted});
      check({tag, ".fetch_en"}, {31'b0, bus.fetch_en}, {31'b0, !m_halted && ce && !st});
`ifdef PC_ALIGN_CHECK_EN
      check({tag, ".fault"}, {31'b0, bus.addr_fault}, {31'b0, m_fault});
`endif
   endtask

   // Asserts reset between edges, checks the immediate values, releases after one edge.
   task automatic do_reset(string tag);
      reset = 1'b1;
      #1;
      check({tag, ".rst_pc"}, bus.pc_out, RV);
      check({tag, ".rst_act"}, {31'b0, bus.active}, 32'd1);
      check({tag, ".rst_slot"}, {31'b0, bus.delay_slot}, 32'd0);
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      bit          ce, st, rv;
      logic [31:0] tgt;
      drive(1, 0, 0, 32'h0);

      // Directed table from reset: stepping, branch, stall/ce in SLOT, wrap, halt.
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'hBFC00004, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'hBFC00008, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'hBFC0000C, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'hBFC00010, 0, 1, 1));
      vecs.push_back(mk(1, 0, 1, 32'hBFC00100, 32'hBFC00014, 1, 1, 1));
      vecs.push_back(mk(1, 0, 1, 32'h12345678, 32'hBFC00100, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'hBFC00104, 0, 1, 1));
      vecs.push_back(mk(1, 0, 1, 32'hBFC00200, 32'hBFC00108, 1, 1, 1));
      vecs.push_back(mk(1, 1, 0, 32'h0,        32'hBFC00108, 1, 1, 0));
      vecs.push_back(mk(1, 1, 1, 32'h0,        32'hBFC00108, 1, 1, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0,        32'hBFC00108, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'hBFC00200, 0, 1, 1));
      vecs.push_back(mk(1, 0, 1, 32'hBFC00300, 32'hBFC00204, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 32'h0,        32'hBFC00204, 1, 1, 0));
      vecs.push_back(mk(0, 0, 1, 32'h0,        32'hBFC00204, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        32'hBFC00204, 1, 1, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'hBFC00300, 0, 1, 1));
      vecs.push_back(mk(1, 0, 1, 32'hFFFFFFF8, 32'hBFC00304, 1, 1, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'hFFFFFFF8, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'hFFFFFFFC, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h00000000, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h00000004, 0, 1, 1));
      vecs.push_back(mk(1, 0, 1, 32'h00000000, 32'h00000008, 1, 1, 1));
      vecs.push_back(mk(1, 0, 0, 32'h0,        32'h00000000, 0, 0, 0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1, 0, 1, 32'hBFC00100, 32'h00000000, 0, 0, 0));

      // Reset between edges before the first clock edge.
      #2;
      do_reset("init");

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vecs[i].ce, vecs[i].st, vecs[i].rv, vecs[i].tgt);
         tick();
         check({tag, ".pc"}, bus.pc_out, vecs[i].pc);
         check({tag, ".slot"}, {31'b0, bus.delay_slot}, {31'b0, vecs[i].slot});
         check({tag, ".active"}, {31'b0, bus.active}, {31'b0, vecs[i].act});
         check({tag, ".fetch_en"}, {31'b0, bus.fetch_en}, {31'b0, vecs[i].fe});
      end

      // Reset out of HALT.
      drive(1, 0, 0, 32'h0);
      do_reset("halt_exit");

      // Reset mid-SLOT discards the pending target.
      drive(1, 0, 1, 32'hBFC00400);
      tick();
      check("midslot.slot", {31'b0, bus.delay_slot}, 32'd1);
      drive(1, 0, 0, 32'h0);
      do_reset("midslot");
      check("midslot.pc0", bus.pc_out, RV);
      tick();
      check("midslot.pc1", bus.pc_out, 32'hBFC00004);
      check("midslot.slot1", {31'b0, bus.delay_slot}, 32'd0);
      tick();
      check("midslot.pc2", bus.pc_out, 32'hBFC00008);

      // Reset and redirect on the same edge: reset wins.
      drive(1, 0, 1, 32'h00000100);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1, 0, 0, 32'h0);
      check("simul.pc", bus.pc_out, RV);
      check("simul.slot", {31'b0, bus.delay_slot}, 32'd0);
      tick();
      check("simul.pc1", bus.pc_out, 32'hBFC00004);
      check("simul.slot1", {31'b0, bus.delay_slot}, 32'd0);

      // Misaligned target handling.
      do_reset("align");
      drive(1, 0, 1, 32'hBFC00102);
      tick();
      check("align.slotpc", bus.pc_out, 32'hBFC00004);
      drive(1, 0, 0, 32'h0);
      tick();
`ifdef PC_ALIGN_CHECK_EN
      check("align.pc", bus.pc_out, 32'hBFC00004);
      check("align.active", {31'b0, bus.active}, 32'd0);
      check("align.fault", {31'b0, bus.addr_fault}, 32'd1);
      check("align.fetch_en", {31'b0, bus.fetch_en}, 32'd0);
      tick();
      check("align.sticky", {31'b0, bus.addr_fault}, 32'd1);
`else
      check("align.pc", bus.pc_out, 32'hBFC00100);
      check("align.active", {31'b0, bus.active}, 32'd1);
`endif

      // Random traffic against the model, with occasional asynchronous resets.
      drive(1, 0, 0, 32'h0);
      do_reset("rand_start");
      for (int i = 0; i < 3000; i++) begin
         ce = ($urandom_range(0, 7) != 0);
         st = ($urandom_range(0, 5) == 0);
         rv = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 9))
            0:       tgt = HALT;
            1:       tgt = 32'hFFFFFFF8;
`ifdef PC_ALIGN_CHECK_EN
            2:       tgt = $urandom();
`endif
            default: tgt = $urandom() & 32'hFFFF_FFFC;
         endcase
         drive(ce, st, rv, tgt);
         if ($urandom_range(0, 63) == 0) begin
            do_reset("rand_rst");
         end else begin
            tick();
            model_edge(ce, st, rv, tgt);
         end
         model_check("rand", ce, st);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
